// File: rtl/reg_file_sb.sv
// Parametrised register file with hardwired-zero x0, optional write-to-read
// bypass and a per-register busy scoreboard with a registered busy count.
module reg_file_sb #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NUM_REGS = 32,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wen,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] write_data,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [AW:0]     busy_cnt
);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                wr_vld, rsv_vld, same_dst, cnt_inc, cnt_dec;
  logic                byp1, byp2;

  // Qualifying with rst_n keeps bypassed reads at zero while reset is held.
  assign wr_vld   = rst_n && wen && (rd_addr != '0);
  assign rsv_vld  = rst_n && rsv_en && (rsv_addr != '0);
  assign same_dst = rsv_vld && (rsv_addr == rd_addr);

  always_comb begin
    busy_d = busy_q;
    if (wr_vld)  busy_d[rd_addr]  = 1'b0;
    if (rsv_vld) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_inc = rsv_vld && !busy_q[rsv_addr];
    cnt_dec = wr_vld && busy_q[rd_addr] && !same_dst;
    cnt_d   = cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_vld) begin
      regs_q[rd_addr] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign byp1 = BYPASS && wr_vld && (rs1_addr == rd_addr);
  assign byp2 = BYPASS && wr_vld && (rs2_addr == rd_addr);

  assign rs1_data = (rs1_addr == '0) ? '0 : (byp1 ? write_data : regs_q[rs1_addr]);
  assign rs2_data = (rs2_addr == '0) ? '0 : (byp2 ? write_data : regs_q[rs2_addr]);

  // A same-edge re-reserve keeps the stored busy view rather than the release.
  assign rs1_busy = (byp1 && !same_dst) ? 1'b0 : busy_q[rs1_addr];
  assign rs2_busy = (byp2 && !same_dst) ? 1'b0 : busy_q[rs2_addr];

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed vector table, hand-written
// reset/counter sequences and randomized traffic against a behavioural model.
module tb_reg_file_sb;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned AW       = 5;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            wen, rsv_en;
  logic [AW-1:0]   rd_addr, rs1_addr, rs2_addr, rsv_addr;
  logic [XLEN-1:0] write_data;

  logic [XLEN-1:0] rs1_a, rs2_a, rs1_b, rs2_b;
  logic            rs1_busy_a, rs2_busy_a, rs1_busy_b, rs2_busy_b;
  logic [AW:0]     cnt_a, cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .wen(wen), .rd_addr(rd_addr), .write_data(write_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_a), .rs2_data(rs2_a),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rs1_busy(rs1_busy_a), .rs2_busy(rs2_busy_a),
    .busy_cnt(cnt_a)
  );

  reg_file_sb #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS(1'b0)) dut_nob (
    .clk(clk), .rst_n(rst_n), .wen(wen), .rd_addr(rd_addr), .write_data(write_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_b), .rs2_data(rs2_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b),
    .busy_cnt(cnt_b)
  );

  // ---------------- behavioural reference model ----------------
  logic [XLEN-1:0] m_regs [NUM_REGS];
  bit              m_busy [NUM_REGS];

  function automatic int m_cnt();
    int s = 0;
    for (int i = 0; i < int'(NUM_REGS); i++) s += int'(m_busy[i]);
    return s;
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a, input bit byp);
    if (a == 0 || !rst_n) return '0;
    if (byp && wen && rd_addr == a) return write_data;
    return m_regs[a];
  endfunction

  function automatic bit m_busy_rd(input logic [AW-1:0] a, input bit byp);
    if (a == 0 || !rst_n) return 1'b0;
    if (byp && wen && rd_addr == a && !(rsv_en && rsv_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (rst_n) begin
      if (wen && rd_addr != 0) begin
        m_regs[rd_addr] = write_data;
        m_busy[rd_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic cmp(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wen = 1'b0; rd_addr = '0; write_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_all(input string tag);
    cmp({tag, " rs1_data byp"}, rs1_a, m_read(rs1_addr, 1'b1));
    cmp({tag, " rs2_data byp"}, rs2_a, m_read(rs2_addr, 1'b1));
    cmp({tag, " rs1_data nob"}, rs1_b, m_read(rs1_addr, 1'b0));
    cmp({tag, " rs2_data nob"}, rs2_b, m_read(rs2_addr, 1'b0));
    cmp({tag, " rs1_busy byp"}, XLEN'(rs1_busy_a), XLEN'(m_busy_rd(rs1_addr, 1'b1)));
    cmp({tag, " rs2_busy byp"}, XLEN'(rs2_busy_a), XLEN'(m_busy_rd(rs2_addr, 1'b1)));
    cmp({tag, " rs1_busy nob"}, XLEN'(rs1_busy_b), XLEN'(m_busy_rd(rs1_addr, 1'b0)));
    cmp({tag, " rs2_busy nob"}, XLEN'(rs2_busy_b), XLEN'(m_busy_rd(rs2_addr, 1'b0)));
    cmp({tag, " busy_cnt byp"}, XLEN'(cnt_a), XLEN'(m_cnt()));
    cmp({tag, " busy_cnt nob"}, XLEN'(cnt_b), XLEN'(m_cnt()));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit              wen;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wd;
    bit              rsv_en;
    logic [AW-1:0]   rsv;
    logic [AW-1:0]   rs;
    logic [XLEN-1:0] exp_byp;
    logic [XLEN-1:0] exp_nob;
    bit              busy_byp;
    bit              busy_nob;
    logic [AW:0]     cnt_post;
  } vec_t;

  vec_t vt [11];

  initial begin
    vt[0]  = '{1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd0,  5'd0,  64'h0, 64'h0, 1'b0, 1'b0, 6'd0};
    vt[1]  = '{1'b1, 5'd10, 64'h2,                   1'b0, 5'd0,  5'd10, 64'h2, 64'h0, 1'b0, 1'b0, 6'd0};
    vt[2]  = '{1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  5'd10, 64'h2, 64'h2, 1'b0, 1'b0, 6'd0};
    vt[3]  = '{1'b0, 5'd0,  64'h0,                   1'b1, 5'd20, 5'd20, 64'h0, 64'h0, 1'b0, 1'b0, 6'd1};
    vt[4]  = '{1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  5'd20, 64'h0, 64'h0, 1'b1, 1'b1, 6'd1};
    vt[5]  = '{1'b1, 5'd20, 64'h456701023D2,         1'b0, 5'd0,  5'd20, 64'h456701023D2, 64'h0, 1'b0, 1'b1, 6'd0};
    vt[6]  = '{1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  5'd20, 64'h456701023D2, 64'h456701023D2, 1'b0, 1'b0, 6'd0};
    vt[7]  = '{1'b0, 5'd0,  64'h0,                   1'b1, 5'd21, 5'd21, 64'h0, 64'h0, 1'b0, 1'b0, 6'd1};
    vt[8]  = '{1'b1, 5'd21, 64'h012005C2,            1'b1, 5'd21, 5'd21, 64'h012005C2, 64'h0, 1'b1, 1'b1, 6'd1};
    vt[9]  = '{1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  5'd21, 64'h012005C2, 64'h012005C2, 1'b1, 1'b1, 6'd1};
    vt[10] = '{1'b1, 5'd10, 64'h7,                   1'b0, 5'd0,  5'd10, 64'h7, 64'h2, 1'b0, 1'b0, 6'd1};
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check_all("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // table
    for (int i = 0; i < 11; i++) begin
      wen = vt[i].wen; rd_addr = vt[i].rd; write_data = vt[i].wd;
      rsv_en = vt[i].rsv_en; rsv_addr = vt[i].rsv;
      rs1_addr = vt[i].rs; rs2_addr = vt[i].rs;
      #1;
      cmp($sformatf("vec%0d rs1 byp", i), rs1_a, vt[i].exp_byp);
      cmp($sformatf("vec%0d rs2 byp", i), rs2_a, vt[i].exp_byp);
      cmp($sformatf("vec%0d rs1 nob", i), rs1_b, vt[i].exp_nob);
      cmp($sformatf("vec%0d rs2 nob", i), rs2_b, vt[i].exp_nob);
      cmp($sformatf("vec%0d busy byp", i), XLEN'(rs1_busy_a), XLEN'(vt[i].busy_byp));
      cmp($sformatf("vec%0d busy nob", i), XLEN'(rs1_busy_b), XLEN'(vt[i].busy_nob));
      tick();
      cmp($sformatf("vec%0d cnt byp", i), XLEN'(cnt_a), XLEN'(vt[i].cnt_post));
      cmp($sformatf("vec%0d cnt nob", i), XLEN'(cnt_b), XLEN'(vt[i].cnt_post));
    end

    // asynchronous reset mid-cycle, with a pending reservation
    idle_inputs();
    wen = 1'b1; rd_addr = 5'd5; write_data = 64'hDEAD;
    rsv_en = 1'b1; rsv_addr = 5'd7;
    tick();
    idle_inputs();
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    #1;
    cmp("pre-reset x5", rs1_b, 64'hDEAD);
    cmp("pre-reset x7 busy", XLEN'(rs2_busy_b), XLEN'(1'b1));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("async rst x5 byp", rs1_a, 64'h0);
    cmp("async rst x5 nob", rs1_b, 64'h0);
    cmp("async rst cnt", XLEN'(cnt_a), XLEN'(0));
    cmp("async rst x7 busy", XLEN'(rs2_busy_a), XLEN'(1'b0));
    wen = 1'b1; rd_addr = 5'd5; write_data = 64'h1234;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    #1;
    cmp("in-rst bypass x5", rs1_a, 64'h0);
    tick();
    idle_inputs();
    rs1_addr = 5'd5; rs2_addr = 5'd9;
    #1;
    cmp("in-rst write ignored", rs1_b, 64'h0);
    cmp("in-rst rsv ignored cnt", XLEN'(cnt_b), XLEN'(0));
    rst_n = 1'b1;
    tick();
    check_all("post-rst");

    // counter balance
    for (int r = 1; r < 32; r++) begin
      rsv_en = 1'b1; rsv_addr = AW'(r);
      tick();
      cmp($sformatf("fill cnt %0d", r), XLEN'(cnt_a), XLEN'(r));
    end
    rsv_en = 1'b1; rsv_addr = 5'd3;
    wen = 1'b1; rd_addr = 5'd3; write_data = 64'h33;
    tick();
    cmp("swap x3 cnt byp", XLEN'(cnt_a), XLEN'(31));
    cmp("swap x3 cnt nob", XLEN'(cnt_b), XLEN'(31));
    idle_inputs();
    rs1_addr = 5'd3;
    #1;
    cmp("swap x3 busy", XLEN'(rs1_busy_a), XLEN'(1'b1));
    cmp("swap x3 data", rs1_b, 64'h33);
    rsv_en = 1'b1; rsv_addr = 5'd4;
    tick();
    cmp("rsv busy reg cnt", XLEN'(cnt_a), XLEN'(31));
    do_reset();
    wen = 1'b1; rd_addr = 5'd9; write_data = 64'h99;
    tick();
    cmp("idle release cnt", XLEN'(cnt_a), XLEN'(0));

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      if (!rst_n) model_reset();
      wen        = 1'($urandom_range(0, 1));
      rsv_en     = 1'($urandom_range(0, 1));
      write_data = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) begin
        rd_addr  = AW'($urandom_range(0, 3));
        rsv_addr = AW'($urandom_range(0, 3));
        rs1_addr = AW'($urandom_range(0, 3));
        rs2_addr = AW'($urandom_range(0, 3));
      end else begin
        rd_addr  = AW'($urandom);
        rsv_addr = AW'($urandom);
        rs1_addr = AW'($urandom);
        rs2_addr = AW'($urandom);
      end
      #1;
      check_all("rnd");
      tick();
    end
    rst_n = 1'b1;
    idle_inputs();
    tick();
    check_all("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
